// File: rtl/mem_access.sv
// Load/store stage: ALU results pass through, loads/stores run one data-bus transaction.
// Latency: 1 cycle for ALU ops and faults; for memory ops, ack cycle + 1 (at least 2).
// Backpressure: stall_o is high while a bus access is outstanding; valid_i is ignored then.
module mem_access #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_i,
  input  logic [6:0]  opcode_i,
  input  logic [2:0]  funct3_i,
  input  logic        rd_we_i,
  input  logic [4:0]  rd_addr_i,
  input  logic [31:0] rd_data_i,
  input  logic [31:0] rs2_data_i,
  output logic        stall_o,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_ack,
  output logic        valid_o,
  output logic        rd_we,
  output logic [4:0]  rd_addr,
  output logic [31:0] rd_data,
  output logic        misalign_o,
  output logic        timeout_o
);

  typedef enum logic {IDLE, BUS} state_t;

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  // The last BUS cycle allowed before giving up on the ack.
  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  wait_cnt;

  logic        is_load, is_store, is_mem;
  logic        f3_legal, aligned, mem_ok;
  logic [1:0]  off;
  logic [3:0]  be_nxt;
  logic [31:0] wdata_nxt;
  logic        accept, start_bus, bus_done, bus_to;

  // Transaction context captured at accept for the write-back.
  logic        q_load;
  logic        q_rd_we;
  logic [4:0]  q_rd_addr;
  logic [2:0]  q_f3;
  logic [1:0]  q_off;
  logic [31:0] rdata_sh;
  logic [31:0] load_data;

  assign stall_o  = (state == BUS);
  assign dmem_req = (state == BUS);

  assign is_load  = (opcode_i == OP_LOAD);
  assign is_store = (opcode_i == OP_STORE);
  assign is_mem   = is_load | is_store;
  assign off      = rd_data_i[1:0];

  assign accept    = (state == IDLE) && valid_i;
  assign start_bus = accept && is_mem && mem_ok;
  assign bus_done  = (state == BUS) && dmem_ack;
  assign bus_to    = (state == BUS) && !dmem_ack && (wait_cnt == WAIT_LAST);

  // Decode funct3 legality, alignment, byte-lane mask and replicated store data.
  always_comb begin
    f3_legal  = 1'b0;
    aligned   = 1'b0;
    be_nxt    = 4'b1111;
    wdata_nxt = rs2_data_i;
    if (is_load) begin
      f3_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010) ||
                 (funct3_i == 3'b100) || (funct3_i == 3'b101);
    end else if (is_store) begin
      f3_legal = (funct3_i == 3'b000) || (funct3_i == 3'b001) || (funct3_i == 3'b010);
    end
    case (funct3_i[1:0])
      2'b00: begin
        aligned   = 1'b1;
        be_nxt    = 4'b0001 << off;
        wdata_nxt = {4{rs2_data_i[7:0]}};
      end
      2'b01: begin
        aligned   = (off[0] == 1'b0);
        be_nxt    = 4'b0011 << off;
        wdata_nxt = {2{rs2_data_i[15:0]}};
      end
      2'b10: begin
        aligned   = (off == 2'b00);
        be_nxt    = 4'b1111;
        wdata_nxt = rs2_data_i;
      end
      default: begin
        aligned   = 1'b0;
        be_nxt    = 4'b1111;
        wdata_nxt = rs2_data_i;
      end
    endcase
  end

  assign mem_ok = f3_legal && aligned;

  // Shift the addressed lane down to bit 0, then extend according to the load width.
  assign rdata_sh = dmem_rdata >> {q_off, 3'b000};

  // Select and extend load data from the bus word.
  always_comb begin
    load_data = rdata_sh;
    case (q_f3)
      3'b000:  load_data = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
      3'b001:  load_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
      3'b100:  load_data = {24'b0, rdata_sh[7:0]};
      3'b101:  load_data = {16'b0, rdata_sh[15:0]};
      default: load_data = rdata_sh;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  // Next state: enter BUS on a legal memory op, leave on ack or wait expiry.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start_bus) state_nxt = BUS;
      BUS:     if (bus_done || bus_to) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Ack-wait counter: cleared on entry to BUS, counts cycles without ack.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wait_cnt <= 8'd0;
    end else if (start_bus) begin
      wait_cnt <= 8'd0;
    end else if ((state == BUS) && !dmem_ack) begin
      wait_cnt <= wait_cnt + 8'd1;
    end
  end

  // Bus request fields and transaction context, loaded at accept and held through BUS.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_we    <= 1'b0;
      dmem_addr  <= 32'd0;
      dmem_wdata <= 32'd0;
      dmem_be    <= 4'd0;
      q_load     <= 1'b0;
      q_rd_we    <= 1'b0;
      q_rd_addr  <= 5'd0;
      q_f3       <= 3'd0;
      q_off      <= 2'd0;
    end else if (start_bus) begin
      dmem_we    <= is_store;
      dmem_addr  <= {rd_data_i[31:2], 2'b00};
      dmem_wdata <= wdata_nxt;
      dmem_be    <= be_nxt;
      q_load     <= is_load;
      q_rd_we    <= rd_we_i;
      q_rd_addr  <= rd_addr_i;
      q_f3       <= funct3_i;
      q_off      <= off;
    end
  end

  // Registered write-back and single-cycle fault pulses; rd_* hold between results.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_o    <= 1'b0;
      rd_we      <= 1'b0;
      rd_addr    <= 5'd0;
      rd_data    <= 32'd0;
      misalign_o <= 1'b0;
      timeout_o  <= 1'b0;
    end else begin
      valid_o    <= 1'b0;
      misalign_o <= 1'b0;
      timeout_o  <= 1'b0;
      if (accept && !is_mem) begin
        valid_o <= 1'b1;
        rd_we   <= rd_we_i;
        rd_addr <= rd_addr_i;
        rd_data <= rd_data_i;
      end else if (accept && !mem_ok) begin
        valid_o    <= 1'b1;
        misalign_o <= 1'b1;
        rd_we      <= 1'b0;
        rd_addr    <= rd_addr_i;
        rd_data    <= 32'd0;
      end else if (bus_done) begin
        valid_o <= 1'b1;
        rd_we   <= q_load ? q_rd_we : 1'b0;
        rd_addr <= q_rd_addr;
        rd_data <= q_load ? load_data : 32'd0;
      end else if (bus_to) begin
        valid_o   <= 1'b1;
        timeout_o <= 1'b1;
        rd_we     <= 1'b0;
        rd_addr   <= q_rd_addr;
        rd_data   <= 32'd0;
      end
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Randomized + directed bench for mem_access with a scoreboard of expected write-backs.
// A reference model derives each result from opcode/funct3/address rules and the chosen ack delay.
// A monitor pops the scoreboard at every valid_o and checks value and arrival cycle.
module tb_mem_access;

  localparam int T = 4;

  logic        clk;
  logic        rst;
  logic        valid_i;
  logic [6:0]  opcode_i;
  logic [2:0]  funct3_i;
  logic        rd_we_i;
  logic [4:0]  rd_addr_i;
  logic [31:0] rd_data_i;
  logic [31:0] rs2_data_i;
  logic        stall_o;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_rdata;
  logic        dmem_ack;
  logic        valid_o;
  logic        rd_we;
  logic [4:0]  rd_addr;
  logic [31:0] rd_data;
  logic        misalign_o;
  logic        timeout_o;

  mem_access #(.TIMEOUT(T)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .opcode_i(opcode_i), .funct3_i(funct3_i),
    .rd_we_i(rd_we_i), .rd_addr_i(rd_addr_i), .rd_data_i(rd_data_i), .rs2_data_i(rs2_data_i),
    .stall_o(stall_o), .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
    .dmem_wdata(dmem_wdata), .dmem_be(dmem_be), .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack),
    .valid_o(valid_o), .rd_we(rd_we), .rd_addr(rd_addr), .rd_data(rd_data),
    .misalign_o(misalign_o), .timeout_o(timeout_o)
  );

  typedef struct {
    int          cyc;
    logic        we;
    logic [4:0]  addr;
    logic [31:0] data;
    bit          chk_addr;
    bit          chk_data;
    bit          mis;
    bit          to;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: every valid_o consumes one expected result; faults never pulse alone.
  always @(negedge clk) begin
    if (rst) begin
      if (valid_o) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_valid: got valid_o=1, expected no result (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("result_cycle", cyc, e.cyc);
          chk("rd_we", {31'b0, rd_we}, {31'b0, e.we});
          if (e.chk_addr) chk("rd_addr", {27'b0, rd_addr}, {27'b0, e.addr});
          if (e.chk_data) chk("rd_data", rd_data, e.data);
          chk("misalign_o", {31'b0, misalign_o}, {31'b0, e.mis});
          chk("timeout_o", {31'b0, timeout_o}, {31'b0, e.to});
        end
      end else begin
        chk("stray_fault_pulse", {30'b0, misalign_o, timeout_o}, 32'd0);
      end
    end
  end

  // One transaction: model the expected result, drive it, act as the memory for `d` BUS cycles.
  // d = index of the BUS cycle carrying the ack (values above T mean no ack in time).
  task automatic txn(input logic [6:0] op, input logic [2:0] f3, input logic we_i,
                     input logic [4:0] ra, input logic [31:0] a, input logic [31:0] rs2,
                     input int d, input logic [31:0] rdata, input bit gap);
    exp_t        e;
    bit          is_ld, is_st, legal;
    int          size, off, n;
    logic [31:0] lane, ebe, ewd;
    is_ld = (op == 7'b0000011);
    is_st = (op == 7'b0100011);
    size  = f3 & 3;
    off   = a % 4;
    legal = (is_ld && (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) ||
            (is_st && (f3 inside {3'd0, 3'd1, 3'd2}));
    legal = legal && ((a % (1 << size)) == 0);
    if (gap) begin
      @(negedge clk);
      valid_i  = 1'b0;
      dmem_ack = 1'b0;
    end
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("idle_stall", {31'b0, stall_o}, 32'd0);
    chk("idle_req", {31'b0, dmem_req}, 32'd0);
    valid_i = 1'b1; opcode_i = op; funct3_i = f3; rd_we_i = we_i;
    rd_addr_i = ra; rd_data_i = a; rs2_data_i = rs2;
    e = '{cyc: cyc + 1, we: 1'b0, addr: ra, data: 32'd0,
          chk_addr: 1'b0, chk_data: 1'b0, mis: 1'b0, to: 1'b0};
    if (!is_ld && !is_st) begin
      e.we = we_i; e.data = a; e.chk_addr = 1; e.chk_data = 1;
      exp_q.push_back(e);
      return;
    end
    if (!legal) begin
      e.mis = 1'b1;
      exp_q.push_back(e);
      return;
    end
    n = (d <= T) ? d : T;
    e.cyc = cyc + 1 + n;
    if (d > T) begin
      e.to = 1'b1;
    end else if (is_st) begin
      e.chk_data = 1;
    end else begin
      lane = rdata >> (8 * off);
      if (size == 0)      lane = lane % 256;
      else if (size == 1) lane = lane % 65536;
      if (f3 == 3'd0 && lane >= 128)   lane = lane - 256;
      if (f3 == 3'd1 && lane >= 32768) lane = lane - 65536;
      e.we = we_i; e.data = lane; e.chk_addr = 1; e.chk_data = 1;
    end
    exp_q.push_back(e);
    ebe = (size == 0) ? (1 << off) : (size == 1) ? (3 << off) : 15;
    ewd = (size == 0) ? (rs2 % 256) * 32'h0101_0101 :
          (size == 1) ? (rs2 % 65536) * 32'h0001_0001 : rs2;
    for (int k = 1; k <= n; k++) begin
      @(negedge clk);
      valid_i = 1'($urandom); opcode_i = 7'($urandom); funct3_i = 3'($urandom);
      rd_data_i = $urandom; rs2_data_i = $urandom; rd_addr_i = 5'($urandom);
      chk("bus_stall", {31'b0, stall_o}, 32'd1);
      chk("bus_req", {31'b0, dmem_req}, 32'd1);
      chk("bus_addr", dmem_addr, a - off);
      chk("bus_we", {31'b0, dmem_we}, {31'b0, is_st});
      chk("bus_be", {28'b0, dmem_be}, ebe);
      if (is_st) chk("bus_wdata", dmem_wdata, ewd);
      dmem_ack   = (k == d);
      dmem_rdata = (k == d) ? rdata : $urandom;
    end
  endtask

  initial begin
    cyc = 0; n_checks = 0; n_fail = 0;
    rst = 1'b0; valid_i = 1'b0; opcode_i = '0; funct3_i = '0; rd_we_i = 1'b0;
    rd_addr_i = '0; rd_data_i = '0; rs2_data_i = '0; dmem_rdata = '0; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {stall_o, dmem_req, dmem_we, dmem_be, valid_o, rd_we, misalign_o, timeout_o},
        32'd0);
    chk("reset_rd", {rd_addr, rd_data[26:0]}, 32'd0);
    chk("reset_bus", dmem_addr | dmem_wdata | rd_data, 32'd0);
    rst = 1'b1;

    // Directed cases from the block's worked examples.
    txn(7'b0110011, 3'd0, 1'b1, 5'd5, 32'h1234, 32'd0, 0, 32'd0, 0);
    txn(7'b0000011, 3'd0, 1'b1, 5'd7, 32'h103, 32'd0, 3, 32'h80FF_FFFF, 0);
    txn(7'b0100011, 3'd1, 1'b1, 5'd9, 32'h202, 32'h0000_ABCD, 2, 32'd0, 0);
    txn(7'b0000011, 3'd2, 1'b1, 5'd3, 32'h101, 32'd0, 1, 32'd0, 0);
    txn(7'b0000011, 3'd2, 1'b1, 5'd4, 32'h400, 32'd0, 99, 32'd0, 0);
    txn(7'b0000011, 3'd2, 1'b1, 5'd6, 32'h404, 32'd0, T, 32'hCAFE_F00D, 0);
    txn(7'b0000011, 3'd5, 1'b1, 5'd8, 32'h102, 32'd0, 1, 32'h8765_4321, 0);
    txn(7'b0000011, 3'd3, 1'b1, 5'd8, 32'h100, 32'd0, 1, 32'd0, 0);

    // Randomized mix of ALU ops, loads, stores, bad widths, misalignment and timeouts.
    for (int i = 0; i < 300; i++) begin
      logic [6:0] op;
      int sel;
      sel = $urandom_range(0, 4);
      op  = (sel == 0) ? 7'b0110011 : (sel == 1) ? 7'b0010011 :
            (sel <= 3) ? 7'b0000011 : 7'b0100011;
      txn(op, 3'($urandom), 1'($urandom), 5'($urandom), $urandom, $urandom,
          $urandom_range(1, T + 2), $urandom, ($urandom_range(0, 3) == 0));
    end

    @(negedge clk);
    valid_i = 1'b0; dmem_ack = 1'b0;
    repeat (3) @(negedge clk);

    // Reset in the middle of a bus access; a late ack must not produce a result.
    valid_i = 1'b1; opcode_i = 7'b0000011; funct3_i = 3'd2; rd_data_i = 32'h800;
    @(negedge clk);
    valid_i = 1'b0;
    chk("pre_reset_req", {31'b0, dmem_req}, 32'd1);
    #2 rst = 1'b0;
    #1;
    chk("mid_reset_req", {31'b0, dmem_req}, 32'd0);
    chk("mid_reset_outputs", {stall_o, dmem_we, dmem_be, valid_o, rd_we, misalign_o, timeout_o},
        32'd0);
    chk("mid_reset_bus", dmem_addr | dmem_wdata | rd_data | {27'b0, rd_addr}, 32'd0);
    @(negedge clk);
    rst = 1'b1; dmem_ack = 1'b1;
    @(negedge clk);
    dmem_ack = 1'b0;
    chk("post_reset_req", {31'b0, dmem_req}, 32'd0);
    repeat (4) @(negedge clk);

    chk("scoreboard_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
